pwm_capture: RTL and testbench

//  Downstream monitor for the PWM generator. Samples a PWM waveform and measures

---
 rtl/pwm_capture_if.sv | 55 +++++
 rtl/pwm_capture.sv | 218 +++++++++++++++++++++
 tb/tb_pwm_capture.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// -----------------------------------------------------------------------------
// pwm_capture_if
//   Groups the PWM monitor's measurement-side signals so the capture block and
//   whoever drives and observes it share one bundle.
//
//   Signals
//     pwm_in      PWM waveform under measurement (may be asynchronous to clk)
//     clr         synchronous clear of flags, results and measurement state
//     level       synchronized copy of pwm_in
//     high_cnt    high cycles in the last complete PWM period
//     period_cnt  cycles between the last two rising edges
//     meas_valid  one-cycle pulse when high_cnt/period_cnt update
//     stuck_hi    line held high with no falling edge for too long
//     stuck_lo    line held low with no rising edge for too long
//
//   Modports
//     master  drives pwm_in/clr and observes the results (stimulus side)
//     slave   the capture block itself
// -----------------------------------------------------------------------------
interface pwm_capture_if #(
  parameter int CNT_W = 16
);

  logic             pwm_in;
  logic             clr;
  logic             level;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck_hi;
  logic             stuck_lo;

  modport master (
    output pwm_in,
    output clr,
    input  level,
    input  high_cnt,
    input  period_cnt,
    input  meas_valid,
    input  stuck_hi,
    input  stuck_lo
  );

  modport slave (
    input  pwm_in,
    input  clr,
    output level,
    output high_cnt,
    output period_cnt,
    output meas_valid,
    output stuck_hi,
    output stuck_lo
  );

endinterface

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Downstream monitor for the PWM generator. Synchronizes the PWM line,
//   measures high time and period in clk cycles and reports one result per
//   complete period (rising edge to rising edge). A line that shows no edge for
//   TIMEOUT cycles raises stuck_hi or stuck_lo depending on its level.
//
//   Parameters
//     CNT_W        width of the high/period counters and results
//     SYNC_STAGES  depth of the input synchronizer (>= 2)
//     TIMEOUT      edge-free cycles before a stuck flag; <= 2**CNT_W-1
//
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   pwm_capture_if.slave: pwm_in, clr in; level, high_cnt,
//           period_cnt, meas_valid, stuck_hi, stuck_lo out
//
//   Pipeline: pwm_in -> sync chain (level) -> level_d_q -> registered
//   rise/fall -> FSM with registered outputs. A pwm_in rising edge therefore
//   shows up as meas_valid SYNC_STAGES+2 clocks later.
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_C      = {CNT_W{1'b1}};

  // Front end state
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   level_d_q;
  logic                   rise_q;
  logic                   fall_q;

  // Measurement state
  state_t                 state_q;
  logic [CNT_W-1:0]       per_ctr_q;
  logic [CNT_W-1:0]       hi_ctr_q;
  logic [CNT_W-1:0]       edge_ctr_q;
  logic [CNT_W-1:0]       high_cnt_q;
  logic [CNT_W-1:0]       period_cnt_q;
  logic                   meas_valid_q;
  logic                   stuck_hi_q;
  logic                   stuck_lo_q;

  // Combinational next values
  logic                   level;
  logic                   primed;
  logic                   rise_d;
  logic                   fall_d;
  logic                   edge_seen;
  logic                   timeout_fire;
  logic [CNT_W-1:0]       edge_ctr_d;
  logic [CNT_W-1:0]       per_inc;
  logic [CNT_W-1:0]       hi_inc;

  assign level = sync_q[SYNC_STAGES-1];

  // The sync chain and level_d_q come out of reset/clear holding zeros rather
  // than real samples, so a line that is already high would look like a rising
  // edge. fill_q walks a 1 through one stage per clock; edges are only believed
  // once both level and level_d_q hold genuine samples of pwm_in.
  assign primed = fill_q[SYNC_STAGES];
  assign rise_d = primed & level & ~level_d_q;
  assign fall_d = primed & ~level & level_d_q;

  // Input synchronizer, delayed level and registered edge strobes. Registering
  // the strobes keeps the FSM off the synchronizer's output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      fill_q    <= '0;
      level_d_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else if (bus.clr) begin
      sync_q    <= '0;
      fill_q    <= '0;
      level_d_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      fill_q    <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      level_d_q <= level;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  // level_d_q is the line level aligned with rise_q/fall_q, so it is the level
  // the FSM and the stuck detection reason about.
  assign edge_seen = rise_q | fall_q;

  // Edge watchdog: restarts on any edge and saturates at TIMEOUT. The flag
  // fires on the single step from TIMEOUT-1 to TIMEOUT, so it cannot re-fire
  // while the counter sits saturated. An edge in the same cycle wins.
  always_comb begin
    edge_ctr_d = edge_ctr_q;
    if (edge_seen) begin
      edge_ctr_d = '0;
    end else if (edge_ctr_q != TIMEOUT_C) begin
      edge_ctr_d = edge_ctr_q + ONE_C;
    end
  end

  assign timeout_fire = ~edge_seen & (edge_ctr_q == TIMEOUT_M1);

  // Saturating increments; the watchdog normally ends a measurement long before
  // these limits, saturation just guarantees nothing ever wraps.
  assign per_inc = (per_ctr_q == MAX_C) ? per_ctr_q : per_ctr_q + ONE_C;
  assign hi_inc  = (hi_ctr_q  == MAX_C) ? hi_ctr_q  : hi_ctr_q  + ONE_C;

  // Measurement FSM with registered outputs.
  //   IDLE: waiting for the first rising edge; nothing to report yet.
  //   HIGH: counting both the period and the high time.
  //   LOW : counting the period only; the next rising edge closes the period,
  //         publishes the counts and starts the next period at 1 so that the
  //         rise cycle belongs to the new period.
  // A timeout abandons the partial measurement (results hold) and raises the
  // flag matching the line level; the two flags never coexist. A published
  // measurement proves the line is alive again and clears both flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      per_ctr_q    <= '0;
      hi_ctr_q     <= '0;
      edge_ctr_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
    end else if (bus.clr) begin
      state_q      <= IDLE;
      per_ctr_q    <= '0;
      hi_ctr_q     <= '0;
      edge_ctr_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      edge_ctr_q   <= edge_ctr_d;
      if (timeout_fire) begin
        state_q <= IDLE;
        if (level_d_q) begin
          stuck_hi_q <= 1'b1;
          stuck_lo_q <= 1'b0;
        end else begin
          stuck_lo_q <= 1'b1;
          stuck_hi_q <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (rise_q) begin
              state_q   <= HIGH;
              per_ctr_q <= ONE_C;
              hi_ctr_q  <= ONE_C;
            end
          end
          HIGH: begin
            per_ctr_q <= per_inc;
            if (fall_q) begin
              state_q <= LOW;
            end else begin
              hi_ctr_q <= hi_inc;
            end
          end
          LOW: begin
            if (rise_q) begin
              high_cnt_q   <= hi_ctr_q;
              period_cnt_q <= per_ctr_q;
              meas_valid_q <= 1'b1;
              stuck_hi_q   <= 1'b0;
              stuck_lo_q   <= 1'b0;
              state_q      <= HIGH;
              per_ctr_q    <= ONE_C;
              hi_ctr_q     <= ONE_C;
            end else begin
              per_ctr_q <= per_inc;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.level      = level;
  assign bus.high_cnt   = high_cnt_q;
  assign bus.period_cnt = period_cnt_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.stuck_hi   = stuck_hi_q;
  assign bus.stuck_lo   = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//   Directed bench for pwm_capture. Each driven PWM period queues the result
//   the DUT owes for the previous complete period, tagged with the clock cycle
//   its meas_valid must appear in; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 1023;
  localparam int LAT         = SYNC_STAGES + 2;

  typedef struct {
    int hi;
    int per;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   cyc        = 0;
  int   passCount  = 0;
  int   totalCount = 0;
  exp_t sbQ[$];

  int   prevHi      = 0;
  int   prevPer     = 0;
  bit   havePrev    = 1'b0;
  int   lastFallCyc = 0;
  int   riseCyc     = 0;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and cycle count; stimulus and sampling use negedges.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and every pass.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d at cycle %0d",
                tag, observed, expected, cyc);
  endtask

  // Queue the result of the previous complete period, due LAT cycles after
  // the rising edge being driven now.
  task automatic pushPrev();
    exp_t e;
    if (havePrev) begin
      e.hi  = prevHi;
      e.per = prevPer;
      e.cyc = cyc + LAT;
      sbQ.push_back(e);
    end
  endtask

  // Drive one full PWM period; called just after a negedge.
  task automatic applyStimulus(input int hi, input int lo);
    bus.pwm_in = 1'b1;
    pushPrev();
    repeat (hi) @(negedge clk);
    bus.pwm_in  = 1'b0;
    lastFallCyc = cyc;
    repeat (lo) @(negedge clk);
    prevHi   = hi;
    prevPer  = hi + lo;
    havePrev = 1'b1;
  endtask

  // Scoreboard monitor: meas_valid must appear exactly when due, never
  // otherwise, carrying the queued counts with both stuck flags clear.
  always @(negedge clk) begin
    bit   expValid;
    exp_t e;
    expValid = (sbQ.size() > 0) && (sbQ[0].cyc == cyc);
    if (bus.meas_valid !== 1'b0 || expValid) begin
      checkOutput("meas_valid", 32'(bus.meas_valid), 32'(expValid));
      if (expValid) begin
        e = sbQ.pop_front();
        checkOutput("high_cnt", 32'(bus.high_cnt), e.hi);
        checkOutput("period_cnt", 32'(bus.period_cnt), e.per);
        checkOutput("stuck_hi_at_valid", 32'(bus.stuck_hi), 0);
        checkOutput("stuck_lo_at_valid", 32'(bus.stuck_lo), 0);
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.pwm_in = 1'b0;
    bus.clr    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_level", 32'(bus.level), 0);
    checkOutput("rst_high_cnt", 32'(bus.high_cnt), 0);
    checkOutput("rst_period_cnt", 32'(bus.period_cnt), 0);
    checkOutput("rst_meas_valid", 32'(bus.meas_valid), 0);
    checkOutput("rst_stuck_hi", 32'(bus.stuck_hi), 0);
    checkOutput("rst_stuck_lo", 32'(bus.stuck_lo), 0);
    rst = 1'b0;

    // Quiet low line for 50 cycles
    $display("[TB] idle low line");
    repeat (50) @(negedge clk);
    checkOutput("idle_high_cnt", 32'(bus.high_cnt), 0);
    checkOutput("idle_period_cnt", 32'(bus.period_cnt), 0);
    checkOutput("idle_stuck_lo", 32'(bus.stuck_lo), 0);

    // Steady 30/70 waveform
    $display("[TB] 30 high / 70 low");
    for (int i = 0; i < 4; i++) applyStimulus(30, 70);
    checkOutput("level_low_30_70", 32'(bus.level), 0);

    // Switch to 5/11: first result is still the old 30/100
    $display("[TB] 5 high / 11 low");
    for (int i = 0; i < 4; i++) applyStimulus(5, 11);

    // Hold high: closes the last 5/16 period, then times out
    $display("[TB] stuck high");
    bus.pwm_in = 1'b1;
    pushPrev();
    riseCyc = cyc;
    repeat (LAT + TIMEOUT - 1) @(negedge clk);
    checkOutput("stuck_hi_before", 32'(bus.stuck_hi), 0);
    @(negedge clk);
    checkOutput("stuck_hi_set", 32'(bus.stuck_hi), 1);
    checkOutput("stuck_lo_excl", 32'(bus.stuck_lo), 0);
    havePrev = 1'b0;
    repeat (riseCyc + 1100 - cyc) @(negedge clk);
    checkOutput("stuck_hi_hold_high_cnt", 32'(bus.high_cnt), 5);
    checkOutput("stuck_hi_hold_period_cnt", 32'(bus.period_cnt), 16);

    // Restart: flag survives the first rise, clears with the first result
    bus.pwm_in = 1'b0;
    repeat (70) @(negedge clk);
    applyStimulus(30, 70);
    checkOutput("stuck_hi_persists", 32'(bus.stuck_hi), 1);
    applyStimulus(30, 70);
    checkOutput("stuck_hi_cleared", 32'(bus.stuck_hi), 0);
    checkOutput("queue_empty_restart", sbQ.size(), 0);

    // Line stays low after the last fall: stuck low
    $display("[TB] stuck low");
    repeat (lastFallCyc + LAT + TIMEOUT - 1 - cyc) @(negedge clk);
    checkOutput("stuck_lo_before", 32'(bus.stuck_lo), 0);
    @(negedge clk);
    checkOutput("stuck_lo_set", 32'(bus.stuck_lo), 1);
    checkOutput("stuck_hi_excl", 32'(bus.stuck_hi), 0);
    havePrev = 1'b0;
    repeat (lastFallCyc + 1100 - cyc) @(negedge clk);
    checkOutput("stuck_lo_hold_high_cnt", 32'(bus.high_cnt), 30);
    checkOutput("stuck_lo_hold_period_cnt", 32'(bus.period_cnt), 100);

    // Synchronous clear
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    checkOutput("clr_stuck_lo", 32'(bus.stuck_lo), 0);
    checkOutput("clr_high_cnt", 32'(bus.high_cnt), 0);
    checkOutput("clr_period_cnt", 32'(bus.period_cnt), 0);
    repeat (5) @(negedge clk);

    // Reset in the middle of a high phase
    $display("[TB] reset mid-period");
    applyStimulus(30, 70);
    applyStimulus(30, 70);
    bus.pwm_in = 1'b1;
    pushPrev();
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_level", 32'(bus.level), 0);
    checkOutput("midrst_high_cnt", 32'(bus.high_cnt), 0);
    checkOutput("midrst_period_cnt", 32'(bus.period_cnt), 0);
    checkOutput("midrst_meas_valid", 32'(bus.meas_valid), 0);
    havePrev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (13) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (70) @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(30, 70);
    repeat (10) @(negedge clk);
    checkOutput("queue_empty_end", sbQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
